// File: rtl/qbert_move_sequencer.sv
// Avalon-MM master that walks one Qbert jump through the MTL/Qbert controller register map:
// enable, jump code, start pulse, done poll, position readback and done acknowledge.
module qbert_move_sequencer #(
    parameter int READ_LATENCY = 1,
    parameter int POLL_GAP     = 16,
    parameter int POLL_MAX     = 65535,
    parameter int AUTO_ENABLE  = 1,
    parameter int POS_W        = 3
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iCmd_valid,
    input  logic [2:0]       iCmd_jump,
    output logic             oCmd_ready,
    output logic             oDone,
    output logic             oTimeout,
    output logic [POS_W-1:0] oPosition,
    output logic [7:0]       oAvm_address,
    output logic             oAvm_write,
    output logic             oAvm_read,
    output logic [31:0]      oAvm_writedata,
    input  logic [31:0]      iAvm_readdata,
    input  logic             iAvm_waitrequest
);

    localparam logic [7:0]  ADDR_ENABLE   = 8'd0;
    localparam logic [7:0]  ADDR_JUMP     = 8'd7;
    localparam logic [7:0]  ADDR_POSITION = 8'd9;
    localparam logic [7:0]  ADDR_START    = 8'd10;
    localparam logic [7:0]  ADDR_ACK      = 8'd12;
    localparam logic [7:0]  ADDR_DONE     = 8'd13;
    localparam logic [7:0]  LAT_LAST      = 8'(READ_LATENCY - 1);
    localparam logic [7:0]  GAP_LAST      = 8'(POLL_GAP - 1);
    localparam logic [16:0] POLL_LIMIT    = 17'(POLL_MAX);

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_WR_JUMP,
        S_WR_START,
        S_POLL_RD,
        S_POLL_WAIT,
        S_POLL_GAP,
        S_WR_STOP,
        S_RD_POS,
        S_POS_WAIT,
        S_WR_ACK,
        S_WR_ACKCLR,
        S_DONE
    } state_t;

    // Only the low three writedata bits ever carry information; the rest are tied to zero.
    typedef struct packed {
        logic       write;
        logic       read;
        logic [7:0] addr;
        logic [2:0] wdata;
    } bus_t;

    function automatic bus_t bus_wr(input logic [7:0] addr, input logic [2:0] data);
        bus_t b;
        b.write = 1'b1;
        b.read  = 1'b0;
        b.addr  = addr;
        b.wdata = data;
        return b;
    endfunction

    function automatic bus_t bus_rd(input logic [7:0] addr);
        bus_t b;
        b.write = 1'b0;
        b.read  = 1'b1;
        b.addr  = addr;
        b.wdata = 3'd0;
        return b;
    endfunction

    state_t           r_state, w_state;
    bus_t             r_bus, w_bus;
    logic [7:0]       r_cnt, w_cnt;
    logic [15:0]      r_poll, w_poll;
    logic             r_timeout, w_timeout;
    logic [POS_W-1:0] r_pos, w_pos;
    logic             r_ready;
    logic             w_accept;
    logic             w_poll_last;
    logic             w_unused;

    assign w_accept    = (r_bus.write | r_bus.read) & ~iAvm_waitrequest;
    assign w_poll_last = ({1'b0, r_poll} + 17'd1) == POLL_LIMIT;
    assign w_unused    = ^iAvm_readdata[31:POS_W];

    // NOTE: every signal gets a default before the case so no path can leave one unassigned
    // (which would infer a latch); consecutive transfers may keep the strobe high with a new address.
    always_comb begin
        w_state   = r_state;
        w_bus     = r_bus;
        w_cnt     = r_cnt;
        w_poll    = r_poll;
        w_timeout = r_timeout;
        w_pos     = r_pos;
        if (w_accept) begin
            w_bus.write = 1'b0;
            w_bus.read  = 1'b0;
        end

        case (r_state)
            S_INIT: begin
                if (!r_bus.write) begin
                    w_bus = bus_wr(ADDR_ENABLE, 3'd1);
                end else if (w_accept) begin
                    w_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (iCmd_valid && r_ready) begin
                    w_timeout = 1'b0;
                    w_poll    = 16'd0;
                    w_bus     = bus_wr(ADDR_JUMP, iCmd_jump);
                    w_state   = S_WR_JUMP;
                end
            end
            S_WR_JUMP: begin
                if (w_accept) begin
                    w_bus   = bus_wr(ADDR_START, 3'd1);
                    w_state = S_WR_START;
                end
            end
            S_WR_START: begin
                if (w_accept) begin
                    w_bus   = bus_rd(ADDR_DONE);
                    w_state = S_POLL_RD;
                end
            end
            S_POLL_RD: begin
                if (w_accept) begin
                    w_cnt   = 8'd0;
                    w_state = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (r_cnt != LAT_LAST) begin
                    w_cnt = r_cnt + 8'd1;
                end else if (iAvm_readdata[0]) begin
                    w_bus   = bus_wr(ADDR_START, 3'd0);
                    w_state = S_WR_STOP;
                end else if (w_poll_last) begin
                    // Give up, but still run the stop/readback/ack path so the controller is left clean.
                    w_timeout = 1'b1;
                    w_bus     = bus_wr(ADDR_START, 3'd0);
                    w_state   = S_WR_STOP;
                end else begin
                    w_poll = r_poll + 16'd1;
                    if (POLL_GAP == 0) begin
                        w_bus   = bus_rd(ADDR_DONE);
                        w_state = S_POLL_RD;
                    end else begin
                        w_cnt   = 8'd0;
                        w_state = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_bus   = bus_rd(ADDR_DONE);
                    w_state = S_POLL_RD;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_WR_STOP: begin
                if (w_accept) begin
                    w_bus   = bus_rd(ADDR_POSITION);
                    w_state = S_RD_POS;
                end
            end
            S_RD_POS: begin
                if (w_accept) begin
                    w_cnt   = 8'd0;
                    w_state = S_POS_WAIT;
                end
            end
            S_POS_WAIT: begin
                if (r_cnt != LAT_LAST) begin
                    w_cnt = r_cnt + 8'd1;
                end else begin
                    w_pos   = iAvm_readdata[POS_W-1:0];
                    w_bus   = bus_wr(ADDR_ACK, 3'd1);
                    w_state = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                if (w_accept) begin
                    w_bus   = bus_wr(ADDR_ACK, 3'd0);
                    w_state = S_WR_ACKCLR;
                end
            end
            S_WR_ACKCLR: begin
                if (w_accept) begin
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state   <= (AUTO_ENABLE != 0) ? S_INIT : S_IDLE;
            r_bus     <= '0;
            r_cnt     <= 8'd0;
            r_poll    <= 16'd0;
            r_timeout <= 1'b0;
            r_pos     <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bus     <= w_bus;
            r_cnt     <= w_cnt;
            r_poll    <= w_poll;
            r_timeout <= w_timeout;
            r_pos     <= w_pos;
            r_ready   <= (w_state == S_IDLE);
        end
    end

    assign oCmd_ready     = r_ready;
    assign oDone          = (r_state == S_DONE);
    assign oTimeout       = r_timeout;
    assign oPosition      = r_pos;
    assign oAvm_address   = r_bus.addr;
    assign oAvm_write     = r_bus.write;
    assign oAvm_read      = r_bus.read;
    assign oAvm_writedata = {29'd0, r_bus.wdata};

endmodule

// File: tb/tb_qbert_move_sequencer.sv
// Directed bench: two sequencer instances (default poll limit, and POLL_MAX=3) each talking to a
// small registered-readdata slave model that logs every accepted transfer.
module tb_qbert_move_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid [2];
    logic [2:0]  cmd_jump  [2];
    logic        cmd_ready [2];
    logic        done      [2];
    logic        timeout   [2];
    logic [2:0]  position  [2];
    logic [7:0]  avm_addr  [2];
    logic        avm_write [2];
    logic        avm_read  [2];
    logic [31:0] avm_wdata [2];
    logic [31:0] avm_rdata [2];
    logic        waitreq   [2];

    int total = 0;
    int bad   = 0;

    // slave model / monitor state
    int          cyc = 0;
    logic [41:0] bus_log [$];
    int          r13_t [$];
    int          polls    [2] = '{0, 0};
    int          done_abs [2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] pos_word [2] = '{32'd0, 32'd0};
    int          done_cnt [2] = '{0, 0};
    int          both_err = 0;
    int          w10_cnt  = 0;
    int          stall_cnt = 0;
    int          stall_base = 0;
    bit          stall_en = 1'b0;

    always #5 clk = ~clk;

    assign waitreq[0] = stall_en && avm_write[0] && (avm_addr[0] == 8'd10) &&
                        (avm_wdata[0] == 32'd1) && ((stall_cnt - stall_base) < 5);
    assign waitreq[1] = 1'b0;

    qbert_move_sequencer #(.POLL_GAP(16)) u_dut0 (
        .iCLK(clk), .iRST_n(rst_n),
        .iCmd_valid(cmd_valid[0]), .iCmd_jump(cmd_jump[0]), .oCmd_ready(cmd_ready[0]),
        .oDone(done[0]), .oTimeout(timeout[0]), .oPosition(position[0]),
        .oAvm_address(avm_addr[0]), .oAvm_write(avm_write[0]), .oAvm_read(avm_read[0]),
        .oAvm_writedata(avm_wdata[0]), .iAvm_readdata(avm_rdata[0]),
        .iAvm_waitrequest(waitreq[0])
    );

    qbert_move_sequencer #(.POLL_GAP(2), .POLL_MAX(3)) u_dut1 (
        .iCLK(clk), .iRST_n(rst_n),
        .iCmd_valid(cmd_valid[1]), .iCmd_jump(cmd_jump[1]), .oCmd_ready(cmd_ready[1]),
        .oDone(done[1]), .oTimeout(timeout[1]), .oPosition(position[1]),
        .oAvm_address(avm_addr[1]), .oAvm_write(avm_write[1]), .oAvm_read(avm_read[1]),
        .oAvm_writedata(avm_wdata[1]), .iAvm_readdata(avm_rdata[1]),
        .iAvm_waitrequest(waitreq[1])
    );

    // Slave: done_move reads return bit0=1 once the poll number reaches done_abs; upper bits are junk.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (avm_write[k] && avm_read[k]) both_err++;
            if (done[k]) done_cnt[k]++;
            if ((avm_write[k] || avm_read[k]) && !waitreq[k]) begin
                bus_log.push_back({1'(k), avm_write[k], avm_addr[k],
                                   avm_write[k] ? avm_wdata[k] : 32'd0});
                if (avm_read[k]) begin
                    if (avm_addr[k] == 8'd13) begin
                        polls[k]++;
                        avm_rdata[k] <= (polls[k] >= done_abs[k]) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
                        if (k == 0) r13_t.push_back(cyc);
                    end else if (avm_addr[k] == 8'd9) begin
                        avm_rdata[k] <= pos_word[k];
                    end else begin
                        avm_rdata[k] <= 32'd0;
                    end
                end
            end
        end
        if (avm_write[0] && avm_addr[0] == 8'd10 && avm_wdata[0] == 32'd1) w10_cnt++;
        if (waitreq[0]) stall_cnt <= stall_cnt + 1;
        cyc++;
    end

    function automatic logic [41:0] ent(input logic k, input logic w, input logic [7:0] a,
                                        input logic [31:0] d);
        return {k, w, a, d};
    endfunction

    // Issue one command on instance k; cycles counts the accept cycle as 1 and ends on the oDone cycle.
    task automatic run_cmd(input int k, input logic [2:0] jump, output int cycles,
                           output logic to_after);
        int n;
        cycles   = -1;
        to_after = 1'bx;
        n = 0;
        while (!cmd_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!cmd_ready[k]) begin
            bad++;
            $display("FAIL cmd_ready_wait[%0d]: got ready=%0b required 1 within 200 cycles", k, cmd_ready[k]);
            return;
        end
        cmd_valid[k] = 1'b1;
        cmd_jump[k]  = jump;
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        to_after     = timeout[k];
        n = 2;
        while (!done[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!done[k]) begin
            bad++;
            $display("FAIL done_wait[%0d]: got no oDone after %0d cycles, required a pulse", k, n);
            return;
        end
        cycles = n;
    endtask

    task automatic check_log(input logic k, input int base, input logic [41:0] exp [$], input string name);
        logic [41:0] got [$];
        for (int i = base; i < bus_log.size(); i++)
            if (bus_log[i][41] == k) got.push_back(bus_log[i]);
        total++;
        if (got.size() !== exp.size()) begin
            bad++;
            $display("FAIL %s_len: got %0d transfers required %0d", name, got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL %s[%0d]: got w=%0b a=%0d d=%h required w=%0b a=%0d d=%h", name, i,
                         got[i][40], got[i][39:32], got[i][31:0], exp[i][40], exp[i][39:32], exp[i][31:0]);
            end
        end
    endtask

    task automatic test_reset();
        int  base;
        bit  found;
        repeat (2) @(negedge clk);
        total++;
        if ({avm_write[0], avm_read[0], cmd_ready[0], done[0], timeout[0], position[0], cmd_ready[1]} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got w=%0b r=%0b rdy=%0b done=%0b to=%0b pos=%0d rdy1=%0b required all 0",
                     avm_write[0], avm_read[0], cmd_ready[0], done[0], timeout[0], position[0], cmd_ready[1]);
        end
        base = bus_log.size();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (avm_write[0]) found = 1'b1;
        end
        total++;
        if (!found || avm_addr[0] !== 8'd0 || avm_wdata[0] !== 32'd1 || cmd_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL init_write: got found=%0b a=%0d d=%h rdy=%0b required 1 0 00000001 0",
                     found, avm_addr[0], avm_wdata[0], cmd_ready[0]);
        end
        @(negedge clk);
        total++;
        if (cmd_ready[0] !== 1'b1 || avm_write[0] !== 1'b0) begin
            bad++;
            $display("FAIL init_ready: got rdy=%0b w=%0b required 1 0", cmd_ready[0], avm_write[0]);
        end
        repeat (4) @(negedge clk);
        check_log(1'b0, base, '{ent(0, 1, 0, 1)}, "init_log");
    endtask

    task automatic test_single();
        int   base, cycles;
        logic to;
        done_abs[0] = polls[0] + 1;
        pos_word[0] = 32'hABCD_EF05;
        base = bus_log.size();
        run_cmd(0, 3'd3, cycles, to);
        total++;
        if (cycles !== 11) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles required 11", cycles);
        end
        total++;
        if (position[0] !== 3'd5 || timeout[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_result: got pos=%0d to=%0b required 5 0", position[0], timeout[0]);
        end
        @(negedge clk);
        total++;
        if (done[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_after_done: got done=%0b rdy=%0b required 0 1", done[0], cmd_ready[0]);
        end
        check_log(1'b0, base, '{ent(0, 1, 7, 3), ent(0, 1, 10, 1), ent(0, 0, 13, 0), ent(0, 1, 10, 0),
                                ent(0, 0, 9, 0), ent(0, 1, 12, 1), ent(0, 1, 12, 0)}, "single_log");
    endtask

    task automatic test_poll4();
        int   tbase, cycles, min_gap;
        logic to;
        done_abs[0] = polls[0] + 4;
        pos_word[0] = 32'h0000_0002;
        tbase = r13_t.size();
        run_cmd(0, 3'd6, cycles, to);
        total++;
        if (r13_t.size() - tbase !== 4) begin
            bad++;
            $display("FAIL poll4_reads: got %0d polls required 4", r13_t.size() - tbase);
        end
        min_gap = 1000;
        for (int i = tbase + 1; i < r13_t.size(); i++)
            if (r13_t[i] - r13_t[i-1] - 1 < min_gap) min_gap = r13_t[i] - r13_t[i-1] - 1;
        total++;
        if (min_gap < 16) begin
            bad++;
            $display("FAIL poll4_gap: got %0d idle cycles required at least 16", min_gap);
        end
        total++;
        if (timeout[0] !== 1'b0 || position[0] !== 3'd2) begin
            bad++;
            $display("FAIL poll4_result: got to=%0b pos=%0d required 0 2", timeout[0], position[0]);
        end
    endtask

    task automatic test_waitreq();
        int   base, wbase, cycles;
        logic to;
        done_abs[0] = polls[0] + 1;
        pos_word[0] = 32'h0000_0004;
        base  = bus_log.size();
        wbase = w10_cnt;
        stall_base = stall_cnt;
        stall_en   = 1'b1;
        run_cmd(0, 3'd1, cycles, to);
        stall_en = 1'b0;
        total++;
        if (w10_cnt - wbase !== 6 || stall_cnt - stall_base !== 5) begin
            bad++;
            $display("FAIL wait_hold: got presented=%0d stalled=%0d required 6 5", w10_cnt - wbase, stall_cnt - stall_base);
        end
        total++;
        if (cycles !== 16 || position[0] !== 3'd4) begin
            bad++;
            $display("FAIL wait_result: got cycles=%0d pos=%0d required 16 4", cycles, position[0]);
        end
        check_log(1'b0, base, '{ent(0, 1, 7, 1), ent(0, 1, 10, 1), ent(0, 0, 13, 0), ent(0, 1, 10, 0),
                                ent(0, 0, 9, 0), ent(0, 1, 12, 1), ent(0, 1, 12, 0)}, "wait_log");
    endtask

    task automatic test_timeout();
        int   base, cycles;
        logic to;
        done_abs[1] = 32'h7FFF_FFFF;
        pos_word[1] = 32'h1234_5679;
        base = bus_log.size();
        run_cmd(1, 3'd5, cycles, to);
        total++;
        if (timeout[1] !== 1'b1 || position[1] !== 3'd1 || cycles !== 19) begin
            bad++;
            $display("FAIL timeout_result: got to=%0b pos=%0d cycles=%0d required 1 1 19",
                     timeout[1], position[1], cycles);
        end
        check_log(1'b1, base, '{ent(1, 1, 7, 5), ent(1, 1, 10, 1), ent(1, 0, 13, 0), ent(1, 0, 13, 0),
                                ent(1, 0, 13, 0), ent(1, 1, 10, 0), ent(1, 0, 9, 0), ent(1, 1, 12, 1),
                                ent(1, 1, 12, 0)}, "timeout_log");
        done_abs[1] = polls[1] + 1;
        run_cmd(1, 3'd2, cycles, to);
        total++;
        if (to !== 1'b0 || timeout[1] !== 1'b0 || cycles !== 11) begin
            bad++;
            $display("FAIL timeout_clear: got to_after_accept=%0b to=%0b cycles=%0d required 0 0 11",
                     to, timeout[1], cycles);
        end
    endtask

    task automatic test_reset_mid();
        int  n, base, dbase;
        bit  found;
        done_abs[0] = 32'h7FFF_FFFF;
        dbase = done_cnt[0];
        n = 0;
        while (!cmd_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid[0] = 1'b1;
        cmd_jump[0]  = 3'd2;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        n = 0;
        while (!avm_read[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (avm_read[0] !== 1'b1 || avm_addr[0] !== 8'd13) begin
            bad++;
            $display("FAIL midrst_poll: got r=%0b a=%0d required 1 13", avm_read[0], avm_addr[0]);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({avm_write[0], avm_read[0], avm_write[1], avm_read[1], cmd_ready[0], done[0], position[0]} !== 9'd0) begin
            bad++;
            $display("FAIL midrst_async: got w=%0b r=%0b w1=%0b r1=%0b rdy=%0b done=%0b pos=%0d required all 0",
                     avm_write[0], avm_read[0], avm_write[1], avm_read[1], cmd_ready[0], done[0], position[0]);
        end
        @(negedge clk);
        base = bus_log.size();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (avm_write[0]) found = 1'b1;
        end
        total++;
        if (!found || avm_addr[0] !== 8'd0 || avm_wdata[0] !== 32'd1) begin
            bad++;
            $display("FAIL midrst_init: got found=%0b a=%0d d=%h required 1 0 00000001",
                     found, avm_addr[0], avm_wdata[0]);
        end
        repeat (5) @(negedge clk);
        check_log(1'b0, base, '{ent(0, 1, 0, 1)}, "midrst_log");
        total++;
        if (done_cnt[0] !== dbase || cmd_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_nodone: got done_pulses=%0d rdy=%0b required %0d 1",
                     done_cnt[0], cmd_ready[0], dbase);
        end
        total++;
        if (both_err !== 0) begin
            bad++;
            $display("FAIL strobe_overlap: got %0d cycles with read and write required 0", both_err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_jump[k]  = 3'd0;
        end
        test_reset();
        test_single();
        test_poll4();
        test_waitreq();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 time units required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
